// File: rtl/sram_req_arbiter.sv
// Two-to-one arbiter merging instruction-fetch and data SRAM-like channels onto one memory port.
// One transaction is outstanding at a time; simultaneous requests alternate between sources.
module sram_req_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_data_ok,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_data_ok,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_data_ok
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;   // 0 = inst, 1 = data
  logic                last_q, last_d;     // source of the most recent grant
  logic                wr_q, wr_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  // State and latched request fields
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      wr_q    <= 1'b0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state, grant selection and handshake pulses
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    wr_d         = wr_q;
    wstrb_d      = wstrb_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie, data wins unless it was granted last
        if (data_req && (!inst_req || !last_q)) begin
          data_addr_ok = 1'b1;
          owner_d      = 1'b1;
          last_d       = 1'b1;
          wr_d         = data_wr;
          wstrb_d      = data_wstrb;
          addr_d       = data_addr;
          wdata_d      = data_wdata;
          state_d      = REQ;
        end else if (inst_req) begin
          inst_addr_ok = 1'b1;
          owner_d      = 1'b0;
          last_d       = 1'b0;
          wr_d         = 1'b0;
          wstrb_d      = '0;
          addr_d       = inst_addr;
          wdata_d      = '0;
          state_d      = REQ;
        end
      end
      REQ: begin
        if (mem_addr_ok) state_d = WAIT;
      end
      WAIT: begin
        if (mem_data_ok) begin
          if (owner_q) data_data_ok = 1'b1;
          else         inst_data_ok = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req    = (state_q == REQ);
  assign mem_wr     = wr_q;
  assign mem_wstrb  = wstrb_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed, table-driven bench for sram_req_arbiter with hand-written reset sequences.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sram_req_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_rdata(mem_rdata),
    .mem_data_ok(mem_data_ok)
  );

  typedef struct {
    logic        ir;  logic [31:0] ia;
    logic        dr;  logic dw; logic [3:0] ds; logic [31:0] da; logic [31:0] dd;
    logic        mao; logic mdo; logic [31:0] mrd;
    logic [3:0]  e_ok;   // {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}
    logic        e_req;  logic e_wr; logic [3:0] e_strb; logic [31:0] e_addr; logic [31:0] e_wdata;
  } vec_t;

  localparam int NV = 32;
  vec_t tv [NV];

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                              input logic [3:0] ds, input logic [31:0] da, input logic [31:0] dd,
                              input logic mao, input logic mdo, input logic [31:0] mrd,
                              input logic [3:0] e_ok, input logic e_req, input logic e_wr,
                              input logic [3:0] e_strb, input logic [31:0] e_addr, input logic [31:0] e_wdata);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.ds = ds; v.da = da; v.dd = dd;
    v.mao = mao; v.mdo = mdo; v.mrd = mrd;
    v.e_ok = e_ok; v.e_req = e_req; v.e_wr = e_wr; v.e_strb = e_strb; v.e_addr = e_addr; v.e_wdata = e_wdata;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got 0x%08h, want 0x%08h", name, idx, act, exp);
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
  endtask

  task automatic check_all_zero(input int idx);
    check("reset_ok_pulses", idx, 32'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 32'h0);
    check("reset_mem_ctl", idx, 32'({mem_req, mem_wr, mem_wstrb}), 32'h0);
    check("reset_mem_addr", idx, mem_addr, 32'h0);
    check("reset_mem_wdata", idx, mem_wdata, 32'h0);
  endtask

  localparam logic [31:0] DA = 32'h0000_4000, DD = 32'h55AA_55AA;

  initial begin
    // Lone fetch, T0..T2
    tv[0]  = mk(1, 32'hBFC0_0000, 0,0,4'h0,0,0,  0,0,0,            4'b1000, 0,0,4'h0,32'h0,0);
    tv[1]  = mk(0, 32'hBFC0_0000, 0,0,4'h0,0,0,  1,0,0,            4'b0000, 1,0,4'h0,32'hBFC0_0000,0);
    tv[2]  = mk(0, 0,             0,0,4'h0,0,0,  0,1,32'h2401_0001, 4'b0100, 0,0,4'h0,32'hBFC0_0000,0);
    // Store with a one-cycle address stall
    tv[3]  = mk(0, 0, 1,1,4'h3,32'h1000,32'hDEAD_BEEF, 0,0,0, 4'b0010, 0,0,4'h0,32'hBFC0_0000,0);
    tv[4]  = mk(0, 0, 0,0,4'h0,0,0, 0,0,0,               4'b0000, 1,1,4'h3,32'h1000,32'hDEAD_BEEF);
    tv[5]  = mk(0, 0, 0,0,4'h0,0,0, 1,0,0,               4'b0000, 1,1,4'h3,32'h1000,32'hDEAD_BEEF);
    tv[6]  = mk(0, 0, 0,0,4'h0,0,0, 0,1,32'h0000_0000,   4'b0001, 0,1,4'h3,32'h1000,32'hDEAD_BEEF);
    // Stray response in IDLE, then in REQ
    tv[7]  = mk(0, 0, 0,0,4'h0,0,0, 0,1,32'h0000_0099,   4'b0000, 0,1,4'h3,32'h1000,32'hDEAD_BEEF);
    tv[8]  = mk(1, 32'h2000, 0,0,4'h0,0,0, 0,0,0,        4'b1000, 0,1,4'h3,32'h1000,32'hDEAD_BEEF);
    tv[9]  = mk(0, 0, 0,0,4'h0,0,0, 0,1,32'h0000_0077,   4'b0000, 1,0,4'h0,32'h2000,0);
    tv[10] = mk(0, 0, 0,0,4'h0,0,0, 1,0,0,               4'b0000, 1,0,4'h0,32'h2000,0);
    tv[11] = mk(0, 0, 0,0,4'h0,0,0, 0,1,32'h1111_2222,   4'b0100, 0,0,4'h0,32'h2000,0);
    // Contention: both held high, grants data, inst, data, inst
    tv[12] = mk(1, 32'h3000, 1,0,4'hF,DA,DD, 0,0,0,            4'b0010, 0,0,4'h0,32'h2000,0);
    tv[13] = mk(1, 32'h3000, 1,0,4'hF,DA,DD, 1,0,0,            4'b0000, 1,0,4'hF,DA,DD);
    tv[14] = mk(1, 32'h3000, 1,0,4'hF,DA,DD, 0,1,32'hAAAA_0001, 4'b0001, 0,0,4'hF,DA,DD);
    tv[15] = mk(1, 32'h3000, 1,0,4'hF,DA,DD, 0,0,0,            4'b1000, 0,0,4'hF,DA,DD);
    tv[16] = mk(1, 32'h3000, 1,0,4'hF,DA,DD, 1,0,0,            4'b0000, 1,0,4'h0,32'h3000,0);
    tv[17] = mk(1, 32'h3000, 1,0,4'hF,DA,DD, 0,1,32'hAAAA_0002, 4'b0100, 0,0,4'h0,32'h3000,0);
    tv[18] = mk(1, 32'h3000, 1,0,4'hF,DA,DD, 0,0,0,            4'b0010, 0,0,4'h0,32'h3000,0);
    tv[19] = mk(1, 32'h3000, 1,0,4'hF,DA,DD, 1,0,0,            4'b0000, 1,0,4'hF,DA,DD);
    tv[20] = mk(1, 32'h3000, 1,0,4'hF,DA,DD, 0,1,32'hAAAA_0003, 4'b0001, 0,0,4'hF,DA,DD);
    tv[21] = mk(1, 32'h3000, 1,0,4'hF,DA,DD, 0,0,0,            4'b1000, 0,0,4'hF,DA,DD);
    tv[22] = mk(1, 32'h3000, 1,0,4'hF,DA,DD, 1,0,0,            4'b0000, 1,0,4'h0,32'h3000,0);
    tv[23] = mk(0, 0, 0,0,4'h0,0,0,          0,1,32'hAAAA_0004, 4'b0100, 0,0,4'h0,32'h3000,0);
    // Backpressure: address acceptance withheld for 5 cycles while inst_addr moves
    tv[24] = mk(1, 32'h5000, 0,0,4'h0,0,0, 0,0,0, 4'b1000, 0,0,4'h0,32'h3000,0);
    for (int i = 0; i < 5; i++)
      tv[25+i] = mk(1, 32'h5004 + 32'(4*i), 0,0,4'h0,0,0, 0,0,0, 4'b0000, 1,0,4'h0,32'h5000,0);
    tv[30] = mk(0, 0, 0,0,4'h0,0,0, 1,0,0,               4'b0000, 1,0,4'h0,32'h5000,0);
    tv[31] = mk(0, 0, 0,0,4'h0,0,0, 0,1,32'hCAFE_F00D,   4'b0100, 0,0,4'h0,32'h5000,0);

    idle_inputs();
    resetn = 1'b0;
    #2;
    check_all_zero(-1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      inst_req = tv[i].ir; inst_addr = tv[i].ia;
      data_req = tv[i].dr; data_wr = tv[i].dw; data_wstrb = tv[i].ds;
      data_addr = tv[i].da; data_wdata = tv[i].dd;
      mem_addr_ok = tv[i].mao; mem_data_ok = tv[i].mdo; mem_rdata = tv[i].mrd;
      #1;
      check("ok_pulses", i, 32'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 32'(tv[i].e_ok));
      check("mem_req", i, 32'(mem_req), 32'(tv[i].e_req));
      check("mem_wr_wstrb", i, 32'({mem_wr, mem_wstrb}), 32'({tv[i].e_wr, tv[i].e_strb}));
      check("mem_addr", i, mem_addr, tv[i].e_addr);
      check("mem_wdata", i, mem_wdata, tv[i].e_wdata);
      if (tv[i].e_ok[2]) check("inst_rdata", i, inst_rdata, tv[i].mrd);
      if (tv[i].e_ok[0]) check("data_rdata", i, data_rdata, tv[i].mrd);
    end

    // Reset while waiting for the response aborts the transaction
    @(negedge clk); idle_inputs();
    data_req = 1'b1; data_addr = 32'h6000; data_wstrb = 4'hF; #1;
    check("rst_seq_grant", 100, 32'(data_addr_ok), 32'h1);
    @(negedge clk); idle_inputs(); mem_addr_ok = 1'b1; #1;
    check("rst_seq_req", 101, 32'(mem_req), 32'h1);
    @(negedge clk); idle_inputs(); #1;
    check("rst_seq_wait_addr", 102, mem_addr, 32'h6000);
    check("rst_seq_wait_req", 102, 32'(mem_req), 32'h0);
    resetn = 1'b0; #1;
    check_all_zero(103);
    @(negedge clk); resetn = 1'b1;
    @(negedge clk); mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_0BAD; #1;
    check("late_resp_ignored", 104, 32'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 32'h0);
    check("late_resp_no_req", 104, 32'(mem_req), 32'h0);
    // After reset the first tie goes to data
    @(negedge clk); idle_inputs();
    inst_req = 1'b1; inst_addr = 32'h7000; data_req = 1'b1; data_addr = 32'h8000; #1;
    check("post_rst_tie", 105, 32'({inst_addr_ok, data_addr_ok}), 32'b01);
    @(negedge clk); data_req = 1'b0; mem_addr_ok = 1'b1; #1;
    check("post_rst_addr", 106, mem_addr, 32'h8000);
    check("post_rst_no_grant", 106, 32'(inst_addr_ok), 32'h0);
    @(negedge clk); idle_inputs(); mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678; #1;
    check("post_rst_resp", 107, 32'({inst_data_ok, data_data_ok}), 32'b01);
    check("post_rst_rdata", 107, data_rdata, 32'h1234_5678);

    @(negedge clk); idle_inputs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
